// File: rtl/riscv_pkg.sv
// Shared RISC-V front-end definitions: machine width, canonical NOP and the
// fetch-queue slot record.
package riscv_pkg;

    localparam int XLEN = 32;

    // addi x0, x0, 0
    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
        logic        filled;
    } fetch_slot_t;

endpackage

// File: rtl/fetch_queue.sv
// In-order instruction fetch queue: issues imem requests for the current PC, holds
// {pc, instr} pairs until decode pops them, and squashes everything on a redirect.
module fetch_queue
    import riscv_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [XLEN-1:0] pc_f,
    output logic            stall_f,
    input  logic            flush_f,
    output logic            imem_req_valid,
    input  logic            imem_req_ready,
    output logic [XLEN-1:0] imem_req_addr,
    input  logic            imem_rsp_valid,
    input  logic [XLEN-1:0] imem_rsp_data,
    output logic            valid_d,
    output logic [XLEN-1:0] instr_d,
    output logic [XLEN-1:0] pc_d,
    input  logic            stall_d
);

    localparam int IW = $clog2(DEPTH);
    localparam int PW = IW + 1;

    fetch_slot_t     r_slots [DEPTH];
    logic [PW-1:0]   r_alloc_ptr;
    logic [PW-1:0]   r_fill_ptr;
    logic [PW-1:0]   r_read_ptr;
    logic [PW-1:0]   r_discard_cnt;

    logic [PW-1:0]   w_occ;
    logic [PW:0]     w_budget;
    logic            w_fire;
    logic            w_pop;
    logic            w_rsp_keep;
    logic            w_rsp_drop;
    logic [IW-1:0]   w_alloc_idx;
    logic [IW-1:0]   w_fill_idx;
    logic [IW-1:0]   w_read_idx;
    fetch_slot_t     w_head;

    assign w_alloc_idx = r_alloc_ptr[IW-1:0];
    assign w_fill_idx  = r_fill_ptr[IW-1:0];
    assign w_read_idx  = r_read_ptr[IW-1:0];
    assign w_head      = r_slots[w_read_idx];

    // Outstanding squashed responses still occupy request budget until they drain.
    assign w_occ    = r_alloc_ptr - r_read_ptr;
    assign w_budget = {1'b0, w_occ} + {1'b0, r_discard_cnt};

    assign imem_req_valid = !reset && !flush_f && (w_budget < (PW+1)'(DEPTH));
    assign imem_req_addr  = pc_f;
    assign w_fire         = imem_req_valid && imem_req_ready;
    assign stall_f        = !w_fire && !flush_f;

    // A response with nothing outstanding (alloc==fill, no discards) is dropped.
    assign w_rsp_keep = imem_rsp_valid && (r_discard_cnt == '0) && (r_alloc_ptr != r_fill_ptr);
    assign w_rsp_drop = imem_rsp_valid && (r_discard_cnt != '0);

    assign valid_d = (w_occ != '0) && w_head.filled;
    assign instr_d = valid_d ? w_head.instr : NOP_INSTR;
    assign pc_d    = valid_d ? w_head.pc    : '0;
    assign w_pop   = valid_d && !stall_d && !flush_f;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_alloc_ptr   <= '0;
            r_fill_ptr    <= '0;
            r_read_ptr    <= '0;
            r_discard_cnt <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i] <= '0;
            end
        end else if (flush_f) begin
            r_alloc_ptr   <= r_read_ptr;
            r_fill_ptr    <= r_read_ptr;
            r_discard_cnt <= r_discard_cnt + (r_alloc_ptr - r_fill_ptr) - PW'(w_rsp_keep);
            for (int i = 0; i < DEPTH; i++) begin
                r_slots[i].filled <= 1'b0;
            end
        end else begin
            if (w_fire) begin
                r_slots[w_alloc_idx].pc     <= pc_f;
                r_slots[w_alloc_idx].filled <= 1'b0;
                r_alloc_ptr                 <= r_alloc_ptr + PW'(1);
            end
            if (w_rsp_keep) begin
                r_slots[w_fill_idx].instr  <= imem_rsp_data;
                r_slots[w_fill_idx].filled <= 1'b1;
                r_fill_ptr                 <= r_fill_ptr + PW'(1);
            end
            if (w_rsp_drop) begin
                r_discard_cnt <= r_discard_cnt - PW'(1);
            end
            if (w_pop) begin
                r_slots[w_read_idx].filled <= 1'b0;
                r_read_ptr                 <= r_read_ptr + PW'(1);
            end
        end
    end

    a_rsp_without_request: assert property (@(posedge clk) disable iff (reset)
        !(imem_rsp_valid && (r_discard_cnt == '0) && (r_alloc_ptr == r_fill_ptr)))
        else $warning("fetch_queue: imem response with no outstanding request, dropped");

endmodule

// File: tb/tb_fetch_queue.sv
// Directed bench for fetch_queue with a scoreboard of expected {pc, instr} pops,
// a fixed-latency memory model and a PC-register model.
module tb_fetch_queue;
    import riscv_pkg::*;

    localparam int DEPTH = 4;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic [31:0] pc_f;
    logic        stall_f;
    logic        flush_f = 1'b0;
    logic        imem_req_valid;
    logic        imem_req_ready = 1'b0;
    logic [31:0] imem_req_addr;
    logic        imem_rsp_valid = 1'b0;
    logic [31:0] imem_rsp_data = '0;
    logic        valid_d;
    logic [31:0] instr_d;
    logic [31:0] pc_d;
    logic        stall_d = 1'b0;

    always #5 clk = ~clk;

    fetch_queue #(.DEPTH(DEPTH)) dut (
        .clk            (clk),
        .reset          (reset),
        .pc_f           (pc_f),
        .stall_f        (stall_f),
        .flush_f        (flush_f),
        .imem_req_valid (imem_req_valid),
        .imem_req_ready (imem_req_ready),
        .imem_req_addr  (imem_req_addr),
        .imem_rsp_valid (imem_rsp_valid),
        .imem_rsp_data  (imem_rsp_data),
        .valid_d        (valid_d),
        .instr_d        (instr_d),
        .pc_d           (pc_d),
        .stall_d        (stall_d)
    );

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
        end
    endtask

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return 32'hC0DE_0000 | {16'h0000, a[15:0]};
    endfunction

    // PC register: advances by 4 per fire, loads redirect on flush
    logic [31:0] pc_rst = '0;
    logic [31:0] redirect = '0;
    always @(posedge clk or posedge reset) begin
        if (reset)         pc_f <= pc_rst;
        else if (!stall_f) pc_f <= flush_f ? redirect : pc_f + 32'd4;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        logic [31:0] addr;
        int          due;
    } mreq_t;
    mreq_t mq[$];
    int    mem_lat = 1;

    always @(posedge clk) begin
        #1;
        if (mq.size() > 0 && mq[0].due <= cyc) begin
            imem_rsp_valid = 1'b1;
            imem_rsp_data  = mem_word(mq[0].addr);
            void'(mq.pop_front());
        end else begin
            imem_rsp_valid = 1'b0;
            imem_rsp_data  = '0;
        end
    end

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } exp_t;
    exp_t exp_q[$];
    int   fire_cnt = 0;

    always @(posedge reset) exp_q.delete();

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            exp_q.delete();
        end else begin
            if (valid_d && !stall_d && !flush_f) begin
                if (exp_q.size() == 0) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL sb_unexpected: popped pc 0x%08h, expected no instruction", pc_d);
                end else begin
                    e = exp_q.pop_front();
                    check("sb_pc", pc_d, e.pc);
                    check("sb_instr", instr_d, e.instr);
                end
            end
            if (flush_f) exp_q.delete();
            if (imem_req_valid && imem_req_ready) begin
                exp_q.push_back('{pc: pc_f, instr: mem_word(pc_f)});
                mq.push_back('{addr: imem_req_addr, due: cyc + mem_lat});
                fire_cnt++;
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic restart(input logic [31:0] pc0, input int lat);
        imem_req_ready = 1'b0;
        stall_d        = 1'b0;
        flush_f        = 1'b0;
        repeat (8) step();
        mem_lat = lat;
        pc_rst  = pc0;
        reset   = 1'b1;
        step();
        reset   = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        logic [31:0] t1_pc [3];
        logic [31:0] t1_in [3];
        int          fc0;
        bit          found;
        t1_pc = '{32'h0, 32'h4, 32'h8};
        t1_in = '{32'hC0DE_0000, 32'hC0DE_0004, 32'hC0DE_0008};

        // reset state
        @(negedge clk);
        check("rst_valid_d", {31'b0, valid_d}, 32'd0);
        check("rst_instr_d", instr_d, 32'h0000_0013);
        check("rst_pc_d", pc_d, 32'd0);
        check("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("rst_stall_f", {31'b0, stall_f}, 32'd1);
        check("rst_discard", 32'(dut.r_discard_cnt), 32'd0);

        // 1: streaming fetch, 1-cycle memory
        restart(32'h0, 1);
        imem_req_ready = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("t1_stall_f_c%0d", c), {31'b0, stall_f}, 32'd0);
            if (c < 2) begin
                check($sformatf("t1_valid_d_c%0d", c), {31'b0, valid_d}, 32'd0);
            end else begin
                check($sformatf("t1_valid_d_c%0d", c), {31'b0, valid_d}, 32'd1);
                check($sformatf("t1_pc_d_c%0d", c), pc_d, t1_pc[c-2]);
                check($sformatf("t1_instr_d_c%0d", c), instr_d, t1_in[c-2]);
            end
            step();
        end

        // 2: fill to DEPTH with decode stalled, then release
        restart(32'h0, 1);
        fc0 = fire_cnt;
        stall_d = 1'b1;
        imem_req_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            @(negedge clk);
            check($sformatf("t2_stall_f_c%0d", c), {31'b0, stall_f}, 32'd0);
            step();
        end
        for (int c = 4; c < 6; c++) begin
            @(negedge clk);
            check($sformatf("t2_full_req_valid_c%0d", c), {31'b0, imem_req_valid}, 32'd0);
            check($sformatf("t2_full_stall_f_c%0d", c), {31'b0, stall_f}, 32'd1);
            check($sformatf("t2_full_pc_d_c%0d", c), pc_d, 32'h0);
            step();
        end
        stall_d = 1'b0;
        @(negedge clk);
        check("t2_pop_cycle_req_valid", {31'b0, imem_req_valid}, 32'd0);
        check("t2_pop_cycle_valid_d", {31'b0, valid_d}, 32'd1);
        step();
        @(negedge clk);
        check("t2_after_pop_req_valid", {31'b0, imem_req_valid}, 32'd1);
        check("t2_after_pop_pc_d", pc_d, 32'h4);
        check("t2_after_pop_req_addr", imem_req_addr, 32'h10);
        step();
        imem_req_ready = 1'b0;
        @(negedge clk);
        check("t2_fire_count", 32'(fire_cnt - fc0), 32'd5);

        // 3: flush with two requests in flight, 3-cycle memory
        restart(32'h0, 3);
        imem_req_ready = 1'b1;
        step();
        step();
        flush_f  = 1'b1;
        redirect = 32'h100;
        @(negedge clk);
        check("t3_flush_stall_f", {31'b0, stall_f}, 32'd0);
        check("t3_flush_req_valid", {31'b0, imem_req_valid}, 32'd0);
        step();
        flush_f = 1'b0;
        @(negedge clk);
        check("t3_discard_2", 32'(dut.r_discard_cnt), 32'd2);
        check("t3_pc_redirect", pc_f, 32'h100);
        step();
        @(negedge clk);
        check("t3_discard_1", 32'(dut.r_discard_cnt), 32'd1);
        step();
        @(negedge clk);
        check("t3_discard_0", 32'(dut.r_discard_cnt), 32'd0);
        found = 1'b0;
        for (int c = 0; c < 12 && !found; c++) begin
            if (valid_d) found = 1'b1;
            else begin
                step();
                @(negedge clk);
            end
        end
        check("t3_first_valid_seen", {31'b0, found}, 32'd1);
        check("t3_first_pc_d", pc_d, 32'h100);
        check("t3_first_instr_d", instr_d, 32'hC0DE_0100);
        step();
        imem_req_ready = 1'b0;

        // 4: flush coinciding with the only outstanding response
        restart(32'h0, 1);
        imem_req_ready = 1'b1;
        @(negedge clk);
        check("t4_req_valid", {31'b0, imem_req_valid}, 32'd1);
        step();
        imem_req_ready = 1'b0;
        flush_f        = 1'b1;
        redirect       = 32'h300;
        step();
        flush_f = 1'b0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check($sformatf("t4_discard_c%0d", c), 32'(dut.r_discard_cnt), 32'd0);
            check($sformatf("t4_valid_d_c%0d", c), {31'b0, valid_d}, 32'd0);
            step();
        end

        // 5: memory back-pressure holds the PC
        restart(32'h40, 1);
        fc0 = fire_cnt;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            check($sformatf("t5_stall_f_c%0d", c), {31'b0, stall_f}, 32'd1);
            check($sformatf("t5_pc_hold_c%0d", c), pc_f, 32'h40);
            check($sformatf("t5_req_addr_c%0d", c), imem_req_addr, 32'h40);
            step();
        end
        imem_req_ready = 1'b1;
        @(negedge clk);
        check("t5_fire1_addr", imem_req_addr, 32'h40);
        check("t5_fire1_stall_f", {31'b0, stall_f}, 32'd0);
        step();
        @(negedge clk);
        check("t5_fire2_addr", imem_req_addr, 32'h44);
        step();
        imem_req_ready = 1'b0;
        @(negedge clk);
        check("t5_fire_count", 32'(fire_cnt - fc0), 32'd2);

        // 6: async reset with two filled slots and one request outstanding
        restart(32'h0, 3);
        stall_d = 1'b1;
        imem_req_ready = 1'b1;
        step();
        step();
        imem_req_ready = 1'b0;
        step();
        imem_req_ready = 1'b1;
        step();
        imem_req_ready = 1'b0;
        step();
        @(negedge clk);
        check("t6_pre_valid_d", {31'b0, valid_d}, 32'd1);
        check("t6_pre_fill_ptr", 32'(dut.r_fill_ptr), 32'd2);
        check("t6_pre_alloc_ptr", 32'(dut.r_alloc_ptr), 32'd3);
        pc_rst = 32'h0;
        reset  = 1'b1;
        #1;
        check("t6_rst_valid_d", {31'b0, valid_d}, 32'd0);
        check("t6_rst_instr_d", instr_d, 32'h0000_0013);
        check("t6_rst_alloc_ptr", 32'(dut.r_alloc_ptr), 32'd0);
        check("t6_rst_read_ptr", 32'(dut.r_read_ptr), 32'd0);
        @(posedge clk);
        #2;
        reset = 1'b0;
        step();
        @(negedge clk);
        check("t6_late_valid_d", {31'b0, valid_d}, 32'd0);
        check("t6_late_fill_ptr", 32'(dut.r_fill_ptr), 32'd0);
        check("t6_late_alloc_ptr", 32'(dut.r_alloc_ptr), 32'd0);
        check("t6_late_discard", 32'(dut.r_discard_cnt), 32'd0);
        stall_d = 1'b0;
        repeat (3) step();

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
